// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller.
// Lookups hit in the same cycle. A miss refills the whole line through a word-serial req/ack burst.
module icache_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int W  = $clog2(WORDS);
    localparam int L  = $clog2(LINES);
    localparam int TW = 32 - W - L - 2;
    localparam int BW = 30 - W;

    localparam logic [W-1:0] CNT_ONE  = W'(1'b1);
    localparam logic [W-1:0] CNT_LAST = W'(WORDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;

    logic [W-1:0]    off_s;
    logic [L-1:0]    idx_s;
    logic [TW-1:0]   tag_s;
    logic [BW-1:0]   pc_line_s;
    logic            pc_byte_unused_s;

    logic [LINES-1:0] valid_r;
    logic [TW-1:0]    tag_r  [LINES];
    logic [31:0]      data_r [LINES*WORDS];

    // The latched line number carries both the fill index and the fill tag.
    logic [BW-1:0]   base_hi_r;
    logic [L-1:0]    fill_idx_s;
    logic [TW-1:0]   fill_tag_s;
    logic [W-1:0]    cnt_r;
    logic            mem_req_r;
    logic [31:0]     mem_addr_r;

    logic            lookup_s;
    logic            miss_s;
    logic            ack_s;
    logic            last_s;
    logic [31:0]     next_addr_s;

    assign off_s            = pc[W+1:2];
    assign idx_s            = pc[W+L+1:W+2];
    assign tag_s            = pc[31:W+L+2];
    assign pc_line_s        = pc[31:W+2];
    assign pc_byte_unused_s = ^pc[1:0];

    assign fill_idx_s  = base_hi_r[L-1:0];
    assign fill_tag_s  = base_hi_r[BW-1:L];
    assign lookup_s    = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    // Reset outranks a same-cycle ack, so that word is dropped.
    assign ack_s       = (state_r == ST_FILL) && mem_req_r && mem_ack && !rst;
    assign last_s      = (cnt_r == CNT_LAST);
    assign next_addr_s = {base_hi_r, cnt_r + CNT_ONE, 2'b00};

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (miss_s) begin
                    state_nx_s = ST_FILL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (ack_s && last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_FILL;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: zero-latency hit and miss detection in IDLE only
    always_comb begin
        hit    = 1'b0;
        miss_s = 1'b0;
        instr  = data_r[{idx_s, off_s}];
        case (state_r)
            ST_IDLE: begin
                if (!rst) begin
                    hit    = lookup_s;
                    miss_s = !lookup_s;
                end else begin
                    hit    = 1'b0;
                    miss_s = 1'b0;
                end
            end
            ST_FILL: begin
                hit    = 1'b0;
                miss_s = 1'b0;
            end
            default: begin
                hit    = 1'b0;
                miss_s = 1'b0;
            end
        endcase
    end

    // Refill request, address, word counter and valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
            cnt_r      <= {W{1'b0}};
            valid_r    <= {LINES{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (miss_s) begin
                        mem_req_r      <= 1'b1;
                        mem_addr_r     <= {pc_line_s, {(W+2){1'b0}}};
                        cnt_r          <= {W{1'b0}};
                        valid_r[idx_s] <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (ack_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (last_s) begin
                            mem_req_r           <= 1'b0;
                            valid_r[fill_idx_s] <= 1'b1;
                        end else begin
                            mem_addr_r <= next_addr_s;
                        end
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Latch the missing line so a moving pc cannot redirect the fill
    always_ff @(posedge clk) begin
        if (miss_s) begin
            base_hi_r <= pc_line_s;
        end
    end

    // Data and tag arrays are never cleared; valid bits guard them
    always_ff @(posedge clk) begin
        if (ack_s) begin
            data_r[{fill_idx_s, cnt_r}] <= mem_rdata;
        end
        if (ack_s && last_s) begin
            tag_r[fill_idx_s] <= fill_tag_s;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomised scoreboard bench for icache_ctrl against a line-address model of the cache.
module tb_icache_ctrl;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam int LINE_BYTES = 4 * WORDS;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    icache_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .instr     (instr),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        bit          miss;
        int          low;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          checks = 0;
    int          errors = 0;

    bit          m_valid [LINES];
    logic [31:0] m_line  [LINES];
    bit          pat [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_00A0 + {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return (a / 32'(LINE_BYTES)) * 32'(LINE_BYTES);
    endfunction

    function automatic int index_of(input logic [31:0] a);
        return int'((a / 32'(LINE_BYTES)) % 32'(LINES));
    endfunction

    task automatic drive_mem(input int mode, inout int k);
        if (mem_req) begin
            mem_rdata = mem_word(mem_addr);
            case (mode)
                0: mem_ack = 1'b1;
                1: begin
                    mem_ack = pat[k % 7];
                    k++;
                end
                default: mem_ack = 1'($urandom_range(0, 1));
            endcase
        end else begin
            mem_rdata = $urandom;
            mem_ack   = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input int mode);
        exp_t        e;
        logic [31:0] base;
        int          idx;
        int          k;
        bit          done;
        base = line_of(a);
        idx  = index_of(a);
        @(posedge clk);
        #1;
        pc      = a;
        e.instr = mem_word(a);
        e.miss  = !(m_valid[idx] && (m_line[idx] == base));
        e.low   = e.miss ? ((mode == 0) ? WORDS + 1 : -1) : 0;
        if (e.miss) begin
            for (int i = 0; i < WORDS; i++) addr_q.push_back(base + 32'(4 * i));
            m_valid[idx] = 1'b1;
            m_line[idx]  = base;
        end
        exp_q.push_back(e);
        k    = 0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            drive_mem(mode, k);
            @(negedge clk);
            if (hit) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            $display("FAIL fetch_timeout pc=%h got no hit required hit", a);
            $fatal(1);
        end
    endtask

    task automatic reset_mid_fill(input logic [31:0] a);
        int acks;
        logic [31:0] base;
        acks = 0;
        base = line_of(a);
        @(posedge clk);
        #1;
        pc = a;
        for (int i = 0; i < WORDS; i++) addr_q.push_back(base + 32'(4 * i));
        for (int c = 0; c < 50 && acks < 2; c++) begin
            mem_rdata = mem_req ? mem_word(mem_addr) : $urandom;
            mem_ack   = 1'b1;
            @(negedge clk);
            if (mem_req && mem_ack) acks++;
            @(posedge clk);
            #1;
        end
        if (acks < 2) begin
            $display("FAIL midfill_acks got %0d required 2", acks);
            $fatal(1);
        end
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        @(posedge clk);
        #1;
        rst = 1'b0;
        addr_q.delete();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    // Monitor: burst addresses, reset behaviour and every hit against the scoreboard
    bit prev_rst   = 1'b0;
    bit prev_final = 1'b0;
    bit final_now;
    int burst_acks = 0;
    int low_cnt    = 0;
    exp_t got_e;

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (hit !== 1'b0) begin
                errors++;
                $display("FAIL rst_hit got %b required 0", hit);
            end
            if (prev_rst) begin
                checks++;
                if (mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_req got %b required 0", mem_req);
                end
            end
            burst_acks = 0;
            low_cnt    = 0;
            prev_final = 1'b0;
            prev_rst   = 1'b1;
        end else begin
            if (prev_rst) begin
                checks++;
                if (mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL post_rst_req got %b required 0", mem_req);
                end
            end
            final_now = 1'b0;
            if (mem_req) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_req got mem_req=1 addr=%h required no request", mem_addr);
                end else begin
                    if (mem_addr !== addr_q[0]) begin
                        errors++;
                        $display("FAIL mem_addr got %h required %h", mem_addr, addr_q[0]);
                    end
                    if (mem_ack) begin
                        void'(addr_q.pop_front());
                        burst_acks++;
                        if (burst_acks == WORDS) begin
                            final_now  = 1'b1;
                            burst_acks = 0;
                        end
                    end
                end
            end
            if (hit) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_hit pc=%h got hit required none", pc);
                end else begin
                    got_e = exp_q.pop_front();
                    if (instr !== got_e.instr) begin
                        errors++;
                        $display("FAIL instr pc=%h got %h required %h", pc, instr, got_e.instr);
                    end
                    checks++;
                    if (got_e.miss && !prev_final) begin
                        errors++;
                        $display("FAIL refill_end pc=%h got hit without final ack required hit after final ack", pc);
                    end else if (!got_e.miss && low_cnt != 0) begin
                        errors++;
                        $display("FAIL hit_latency pc=%h got %0d stall cycles required 0", pc, low_cnt);
                    end
                    if (got_e.low > 0) begin
                        checks++;
                        if (low_cnt != got_e.low) begin
                            errors++;
                            $display("FAIL miss_penalty pc=%h got %0d required %0d", pc, low_cnt, got_e.low);
                        end
                    end
                    checks++;
                    if (addr_q.size() != 0) begin
                        errors++;
                        $display("FAIL burst_len pc=%h got %0d words left required 0", pc, addr_q.size());
                    end
                end
                low_cnt = 0;
            end else begin
                low_cnt++;
                if (low_cnt > 200) begin
                    errors++;
                    $display("FAIL hit_timeout pc=%h got hit=0 for %0d cycles required hit", pc, low_cnt);
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $finish;
                end
            end
            prev_final = final_now;
            prev_rst   = 1'b0;
        end
    end

    // Stimulus: directed scenarios, then random fetches over a few conflicting tags
    initial begin
        logic [31:0] a;
        int mode;
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = 32'h0;
        end
        rst       = 1'b1;
        pc        = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        do_fetch(32'h0000_0000, 0);
        do_fetch(32'h0000_000C, 0);
        for (int i = 0; i < 3; i++) do_fetch(32'h0000_000C, 0);
        do_fetch(32'h0000_0000, 0);
        do_fetch(32'h0000_0014, 1);
        do_fetch(32'h0000_0010, 0);
        do_fetch(32'h0000_0100, 0);
        do_fetch(32'h0000_0000, 0);
        reset_mid_fill(32'h0000_0040);
        do_fetch(32'h0000_0040, 0);
        do_fetch(32'h0000_0000, 0);

        for (int n = 0; n < 150; n++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            mode = $urandom_range(0, 2);
            do_fetch(a, mode);
        end

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
